iadder_spec_vl: RTL and testbench



---
 rtl/iadder_spec_pkg.sv | 20 ++
 rtl/iadder_spec_core.sv | 41 ++++
 rtl/iadder_spec_vl.sv | 151 +++++++++++++++
 tb/tb_iadder_spec_vl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/iadder_spec_pkg.sv
// Shared constants and state encoding for the variable-latency segmented-carry adder.
// Derived constants describe the default 16-bit configuration.
package iadder_spec_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_SEG   = 4;
    localparam int unsigned DEF_STEP  = 2;
    localparam int unsigned DEF_CHUNK = 4;
    localparam int unsigned DEF_CNTW  = 16;

    localparam int unsigned K      = (DEF_WIDTH - DEF_SEG) / DEF_STEP;
    localparam int unsigned NCHUNK = DEF_WIDTH / DEF_CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        CORRECT = 1'b1
    } state_e;

endpackage

// File: rtl/iadder_spec_core.sv
// Combinational speculative adder: overlapping SEG-bit windows with carry-in 0,
// plus a conservative flag for every operand pair where speculation may be wrong.
module iadder_spec_core
    import iadder_spec_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG   = DEF_SEG,
    parameter int unsigned STEP  = DEF_STEP
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             err
);

    localparam int unsigned NWIN = (WIDTH - SEG) / STEP;

    logic [NWIN-1:0] win_err;

    assign sum[SEG-1:0] = a[SEG-1:0] + b[SEG-1:0];

    for (genvar k = 1; k <= NWIN; k++) begin : g_win
        localparam int unsigned B = k * STEP;
        logic [SEG:0] s;
        logic         unused_bits;

        assign s = {1'b0, a[B+SEG-1:B]} + {1'b0, b[B+SEG-1:B]};
        assign sum[B+SEG-1:B+SEG-STEP] = s[SEG-1:SEG-STEP];
        // A carry can only be missed if it propagates through the whole low part of the window.
        assign win_err[k-1] = &(a[B+SEG-STEP-1:B] ^ b[B+SEG-STEP-1:B]);
        assign unused_bits = ^{s[SEG], s[SEG-STEP-1:0]};

        if (k == NWIN) begin : g_cout
            assign cout = s[SEG];
        end
    end

    assign err = |win_err;

endmodule

// File: rtl/iadder_spec_vl.sv
// Variable-latency approximate adder: one-cycle speculative result, or a serial
// chunk-by-chunk exact correction when exact mode is requested and an error is predicted.
module iadder_spec_vl
    import iadder_spec_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SEG   = DEF_SEG,
    parameter int unsigned STEP  = DEF_STEP,
    parameter int unsigned CHUNK = DEF_CHUNK,
    parameter int unsigned CNTW  = DEF_CNTW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_err,
    output logic             out_exact,
    output logic [CNTW-1:0]  corr_cnt
);

    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             valid_q, valid_d, cout_q, cout_d, err_q, err_d, exact_q, exact_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;

    logic [WIDTH-1:0] apx_sum;
    logic             apx_cout, apx_err;
    logic [CHUNK:0]   csum;
    logic             accept;

    iadder_spec_core #(
        .WIDTH (WIDTH),
        .SEG   (SEG),
        .STEP  (STEP)
    ) u_core (
        .a    (in_a),
        .b    (in_b),
        .sum  (apx_sum),
        .cout (apx_cout),
        .err  (apx_err)
    );

    assign in_ready = (state_q == IDLE) && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    // Operand registers shift right each step, so the active chunk is always the low one.
    assign csum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        valid_d = valid_q;
        cout_d  = cout_q;
        err_d   = err_q;
        exact_d = exact_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!in_mode || !apx_err) begin
                        valid_d = 1'b1;
                        sum_d   = apx_sum;
                        cout_d  = apx_cout;
                        err_d   = apx_err;
                        exact_d = !apx_err;
                    end else begin
                        a_d     = in_a;
                        b_d     = in_b;
                        idx_d   = '0;
                        carry_d = 1'b0;
                        state_d = CORRECT;
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
            end
            CORRECT: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                sum_d   = {csum[CHUNK-1:0], sum_q[WIDTH-1:CHUNK]};
                carry_d = csum[CHUNK];
                idx_d   = idx_q + 1'b1;
                if (idx_q == IW'(NCH - 1)) begin
                    valid_d = 1'b1;
                    cout_d  = csum[CHUNK];
                    err_d   = 1'b1;
                    exact_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            valid_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            exact_q <= 1'b0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            exact_q <= exact_d;
            carry_q <= carry_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_err   = err_q;
    assign out_exact = exact_q;
    assign corr_cnt  = cnt_q;

endmodule

// File: tb/tb_iadder_spec_vl.sv
// Directed and streamed checks of iadder_spec_vl in its default 16-bit configuration.
module tb_iadder_spec_vl;
    import iadder_spec_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_cout, out_err, out_exact;
    logic [15:0] corr_cnt;

    logic [15:0] ref_a = '0, ref_b = '0, ref_sum;
    logic        ref_cout, ref_err;

    int vectors = 0;
    int miscompares = 0;
    int exp_corr = 0;

    always #5 clk = ~clk;

    iadder_spec_vl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_err   (out_err),
        .out_exact (out_exact),
        .corr_cnt  (corr_cnt)
    );

    iadder_spec_core ref_core (
        .a    (ref_a),
        .b    (ref_b),
        .sum  (ref_sum),
        .cout (ref_cout),
        .err  (ref_err)
    );

    // Independent window-by-window model; returns {cout, sum}.
    function automatic logic [16:0] approx_model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        logic [4:0]  w;
        logic        c;
        s[3:0] = a[3:0] + b[3:0];
        c = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            w = {1'b0, a[k*2 +: 4]} + {1'b0, b[k*2 +: 4]};
            s[k*2+2 +: 2] = w[3:2];
            c = w[4];
        end
        return {c, s};
    endfunction

    function automatic logic pred_model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        logic        p;
        x = a ^ b;
        p = 1'b0;
        for (int k = 1; k <= 6; k++) p = p | (&x[k*2 +: 2]);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic m);
        in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
        #1;
        chk("in_ready_at_issue", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] s, input logic c,
                           input logic e, input logic x);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"}, 32'(out_sum), 32'(s));
        chk({tag, "_flags"}, 32'({out_cout, out_err, out_exact}), 32'({c, e, x}));
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rm, rp;
        logic [16:0] ap, ex;
        logic [18:0] q[$];
        logic [18:0] e;
        int          sent, got, cyc;
        logic        accepted;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_outputs", 32'({out_sum, out_cout, out_err, out_exact}), 32'd0);
        chk("rst_corr_cnt", 32'(corr_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Exact mode, no predicted error: fast path, latency 1
        issue(16'h4040, 16'h0404, 1'b1);
        chk_out("t1", 16'h4444, 1'b0, 1'b0, 1'b1);
        chk("t1_corr", 32'(corr_cnt), 32'd0);

        // Approximate mode with a missed carry
        issue(16'h00FF, 16'h0001, 1'b0);
        chk_out("t2", 16'h00F0, 1'b0, 1'b1, 1'b0);

        // Same operands, exact mode: four correction cycles
        issue(16'h00FF, 16'h0001, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_busy_in_ready", 32'(in_ready), 32'd0);
            chk("t3_busy_out_valid", 32'(out_valid), 32'd0);
            @(posedge clk); #1;
        end
        chk_out("t3", 16'h0100, 1'b0, 1'b1, 1'b1);
        chk("t3_corr", 32'(corr_cnt), 32'd1);

        // Corrected carry-out, then back-pressure
        issue(16'hFFFF, 16'h0001, 1'b1);
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk_out("t4", 16'h0000, 1'b1, 1'b1, 1'b1);
        chk("t4_corr", 32'(corr_cnt), 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_out("t4_hold", 16'h0000, 1'b1, 1'b1, 1'b1);
            chk("t4_hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_taken", 32'(out_valid), 32'd0);

        // Back-to-back fast-path accepts
        issue(16'h4040, 16'h0404, 1'b0);
        chk_out("b2b_0", 16'h4444, 1'b0, 1'b0, 1'b1);
        issue(16'h1010, 16'h0101, 1'b0);
        chk_out("b2b_1", 16'h1111, 1'b0, 1'b0, 1'b1);

        // Reset during the second correction cycle
        issue(16'h00FF, 16'h0001, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_outputs", 32'({out_sum, out_cout, out_err, out_exact}), 32'd0);
        chk("t5_rst_corr", 32'(corr_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        issue(16'h00FF, 16'h0001, 1'b0);
        chk_out("t5_after", 16'h00F0, 1'b0, 1'b1, 1'b0);
        exp_corr = 0;

        // Random stream, mixed modes, random back-pressure
        sent = 0; got = 0; cyc = 0; accepted = 1'b0;
        while (got < 100 && cyc < 3000) begin
            @(posedge clk); #1;
            cyc++;
            if (accepted) in_valid = 1'b0;
            accepted = 1'b0;
            if (!in_valid && sent < 100) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rm = 1'($urandom_range(0, 1));
                in_a = ra; in_b = rb; in_mode = rm; in_valid = 1'b1;
                ref_a = ra; ref_b = rb;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("stream_unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("stream_sum", 32'(out_sum), 32'(e[15:0]));
                    chk("stream_flags", 32'({out_cout, out_err, out_exact}), 32'(e[18:16]));
                end
                got++;
            end
            if (in_valid && in_ready) begin
                ap = approx_model(in_a, in_b);
                rp = pred_model(in_a, in_b);
                ex = {1'b0, in_a} + {1'b0, in_b};
                chk("core_model", 32'({ref_cout, ref_sum, ref_err}), 32'({ap, rp}));
                if (!rp) chk("no_pred_is_exact", 32'(ap), 32'(ex));
                if (in_mode && rp) begin
                    q.push_back({ex[16], 1'b1, 1'b1, ex[15:0]});
                    exp_corr++;
                end else begin
                    q.push_back({ap[16], rp, !rp, ap[15:0]});
                end
                sent++;
                accepted = 1'b1;
            end
        end
        in_valid = 1'b0;
        chk("stream_results", 32'(got), 32'd100);
        chk("stream_corr_cnt", 32'(corr_cnt), 32'(exp_corr));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
